// File: rtl/sram_emu_pkg.sv
// rtl/sram_emu_pkg.sv - shared SRAM pin widths, FSM state encodings and OOB read value
// Purpose: definitions shared by the SRAM emulator and the SRAM controller.
// Ports:   none (package).
package sram_emu_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;

   localparam logic [15:0] OOB_DATA_DEF = 16'hDEAD;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_HOLD = 2'd1,
      ST_RD_ACT  = 2'd2
   } state_e;

endpackage

// File: rtl/sram_emu_if.sv
// rtl/sram_emu_if.sv - pin-level async SRAM bus
// Purpose: groups the controller-side SRAM pins.
// Ports:   master = SRAM controller (drives strobes/addr/wr_data, receives rd_data);
//          slave  = SRAM device or emulator (receives strobes/addr/wr_data, drives rd_data).
interface sram_emu_if
   import sram_emu_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W
);
   logic              sram_ce_n;
   logic              sram_we_n;
   logic              sram_oe_n;
   logic              sram_ub_n;
   logic              sram_lb_n;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_wr_data;
   logic [15:0]       sram_rd_data;

   modport master (
      output sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
      output sram_addr, sram_wr_data,
      input  sram_rd_data
   );

   modport slave (
      input  sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n,
      input  sram_addr, sram_wr_data,
      output sram_rd_data
   );
endinterface

// File: rtl/sram_emu_array.sv
// rtl/sram_emu_array.sv - word array with per-byte write enables and async or sync read
// Purpose: 2**DEPTH_LOG2 x DATA_W storage; contents are never reset.
// Ports:   clk     in  system clock
//          we_i    in  write strobe (one cycle per committed write)
//          be_i    in  byte enables, [1] = bits 15:8, [0] = bits 7:0
//          addr_i  in  word address, shared by read and write
//          wdata_i in  write data
//          rdata_o out read data: combinational (RD_LATENCY=0) or registered (RD_LATENCY=1)
module sram_emu_array
   import sram_emu_pkg::*;
#(
   parameter int DATA_W     = SRAM_DATA_W,
   parameter int DEPTH_LOG2 = 12,
   parameter int RD_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [1:0]            be_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we_i) begin
         if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
         if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      end
   end

   generate
      if (RD_LATENCY == 0) begin : g_async_rd
         assign rdata_o = mem_q[addr_i];
      end else begin : g_sync_rd
         // Read-before-write: a same-edge write is seen on the following read.
         logic [DATA_W-1:0] rdata_q;
         always_ff @(posedge clk) begin
            rdata_q <= mem_q[addr_i];
         end
         assign rdata_o = rdata_q;
      end
   endgenerate

endmodule

// File: rtl/sram_emu.sv
// rtl/sram_emu.sv - synchronous emulator of the external 16-bit async SRAM
// Purpose: answers the pin-level SRAM bus from an internal array; one write
//          commit per contiguous write window, bus-hold on the read data.
// Ports:   clk      in   system clock, all state on posedge
//          rst_n    in   synchronous active-low reset (array not cleared)
//          bus      slave SRAM pins (sram_emu_if)
//          wr_count out  committed-write counter, wraps
//          rd_count out  read-window counter, wraps
//          oob_err  out  sticky flag: access at or above 2**DEPTH_LOG2
module sram_emu
   import sram_emu_pkg::*;
#(
   parameter int          ADDR_W     = SRAM_ADDR_W,
   parameter int          DATA_W     = SRAM_DATA_W,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          RD_LATENCY = 0,
   parameter logic [15:0] OOB_DATA   = OOB_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   sram_emu_if.slave   bus,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count,
   output logic        oob_err
);

   state_e            state_q, state_d;
   logic [15:0]       wr_cnt_q, wr_cnt_d;
   logic [15:0]       rd_cnt_q, rd_cnt_d;
   logic              oob_q, oob_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_oob_q, rd_oob_d;

   logic              wr_act, rd_act, in_range;
   logic              commit, rd_open;
   logic [ADDR_W-1:0] addr_hi;
   logic [DATA_W-1:0] arr_rdata, rd_word, rd_data;
   logic              rd_sel, oob_sel;

   // we_n low excludes a read, so write wins when we_n and oe_n are both low.
   assign wr_act   = !bus.sram_ce_n && !bus.sram_we_n;
   assign rd_act   = !bus.sram_ce_n &&  bus.sram_we_n && !bus.sram_oe_n;
   assign addr_hi  = bus.sram_addr >> DEPTH_LOG2;
   assign in_range = (addr_hi == '0);

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      rd_open = 1'b0;
      case (state_q)
         ST_IDLE, ST_RD_ACT: begin
            if (wr_act) begin
               commit  = 1'b1;
               state_d = ST_WR_HOLD;
            end else if (rd_act) begin
               rd_open = (state_q == ST_IDLE);
               state_d = ST_RD_ACT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_HOLD: begin
            // Still inside the window that already committed: ignore addr/data.
            if (wr_act) begin
               state_d = ST_WR_HOLD;
            end else if (rd_act) begin
               rd_open = 1'b1;
               state_d = ST_RD_ACT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sram_emu_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .RD_LATENCY (RD_LATENCY)
   ) u_array (
      .clk     (clk),
      .we_i    (commit && in_range && rst_n),
      .be_i    ({!bus.sram_ub_n, !bus.sram_lb_n}),
      .addr_i  (bus.sram_addr[DEPTH_LOG2-1:0]),
      .wdata_i (bus.sram_wr_data),
      .rdata_o (arr_rdata)
   );

   // With a registered array the read qualifiers are delayed to line up with the data.
   assign rd_sel  = (RD_LATENCY == 0) ? rd_act    : rd_pend_q;
   assign oob_sel = (RD_LATENCY == 0) ? !in_range : rd_oob_q;
   assign rd_word = oob_sel ? OOB_DATA : arr_rdata;
   assign rd_data = rd_sel ? rd_word : hold_q;

   always_comb begin
      wr_cnt_d  = wr_cnt_q + {15'd0, commit};
      rd_cnt_d  = rd_cnt_q + {15'd0, rd_open};
      oob_d     = oob_q | ((wr_act | rd_act) & !in_range);
      rd_pend_d = rd_act;
      rd_oob_d  = !in_range;
      hold_d    = rd_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         oob_q     <= 1'b0;
         hold_q    <= '0;
         rd_pend_q <= 1'b0;
         rd_oob_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         oob_q     <= oob_d;
         hold_q    <= hold_d;
         rd_pend_q <= rd_pend_d;
         rd_oob_q  <= rd_oob_d;
      end
   end

   assign bus.sram_rd_data = rd_data;
   assign wr_count         = wr_cnt_q;
   assign rd_count         = rd_cnt_q;
   assign oob_err          = oob_q;

endmodule

// File: tb/tb_sram_emu.sv
// tb/tb_sram_emu.sv - self-checking bench for sram_emu
module tb_sram_emu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_emu_if #(.ADDR_W(20)) bus ();
   sram_emu_if #(.ADDR_W(20)) bus_s ();

   logic [15:0] wc, rc, wc_s, rc_s;
   logic        oob, oob_s;

   sram_emu #(.ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(12), .RD_LATENCY(0), .OOB_DATA(16'hDEAD)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .wr_count(wc), .rd_count(rc), .oob_err(oob)
   );

   sram_emu #(.ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(4), .RD_LATENCY(0), .OOB_DATA(16'hDEAD)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s), .wr_count(wc_s), .rd_count(rc_s), .oob_err(oob_s)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: window rule as "first cycle of an active run".
   logic [15:0] mm [4096];
   logic [15:0] m_wc, m_rc, m_hold;
   logic        m_oob, m_pw, m_pr;

   task automatic m_reset();
      m_wc = 0; m_rc = 0; m_hold = 0; m_oob = 0; m_pw = 0; m_pr = 0;
   endtask

   function automatic logic [15:0] m_rd();
      logic ra;
      ra = !bus.sram_ce_n && bus.sram_we_n && !bus.sram_oe_n;
      if (!ra) return m_hold;
      if (bus.sram_addr >= 20'd4096) return 16'hDEAD;
      return mm[bus.sram_addr[11:0]];
   endfunction

   task automatic m_tick();
      logic wa, ra, oor;
      wa  = !bus.sram_ce_n && !bus.sram_we_n;
      ra  = !bus.sram_ce_n && bus.sram_we_n && !bus.sram_oe_n;
      oor = bus.sram_addr >= 20'd4096;
      m_hold = m_rd();
      if (wa && !m_pw) begin
         m_wc = m_wc + 16'd1;
         if (!oor) begin
            if (!bus.sram_ub_n) mm[bus.sram_addr[11:0]][15:8] = bus.sram_wr_data[15:8];
            if (!bus.sram_lb_n) mm[bus.sram_addr[11:0]][7:0]  = bus.sram_wr_data[7:0];
         end
      end
      if (ra && !m_pr) m_rc = m_rc + 16'd1;
      if ((wa || ra) && oor) m_oob = 1'b1;
      m_pw = wa;
      m_pr = ra;
      @(posedge clk);
   endtask

   task automatic drive(input bit s, input logic ce, we, oe, ub, lb,
                        input logic [19:0] a, input logic [15:0] d);
      @(negedge clk);
      if (!s) begin
         bus.sram_ce_n = ce; bus.sram_we_n = we; bus.sram_oe_n = oe;
         bus.sram_ub_n = ub; bus.sram_lb_n = lb; bus.sram_addr = a; bus.sram_wr_data = d;
      end else begin
         bus_s.sram_ce_n = ce; bus_s.sram_we_n = we; bus_s.sram_oe_n = oe;
         bus_s.sram_ub_n = ub; bus_s.sram_lb_n = lb; bus_s.sram_addr = a; bus_s.sram_wr_data = d;
      end
      #1;
   endtask

   typedef struct {
      logic        ce, we, oe, ub, lb;
      logic [19:0] a;
      logic [15:0] d, e_rd, e_wc, e_rc;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic ce, we, oe, ub, lb, input logic [19:0] a,
                      input logic [15:0] d, e_rd, e_wc, e_rc);
      vec_t v;
      v.ce = ce; v.we = we; v.oe = oe; v.ub = ub; v.lb = lb;
      v.a = a; v.d = d; v.e_rd = e_rd; v.e_wc = e_wc; v.e_rc = e_rc;
      tbl.push_back(v);
   endtask

   initial begin
      //    ce we oe ub lb addr data     rd        wc  rc
      add(0, 0, 1, 0, 0, 5, 16'hA5C3, 16'h0000, 0, 0);  // write then read
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1, 0);
      add(0, 1, 0, 1, 1, 5, 16'h0000, 16'hA5C3, 1, 0);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hA5C3, 1, 1);
      add(0, 0, 1, 0, 0, 7, 16'h1234, 16'hA5C3, 1, 1);  // byte lanes
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hA5C3, 2, 1);
      add(0, 0, 1, 0, 1, 7, 16'hABCD, 16'hA5C3, 2, 1);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hA5C3, 3, 1);
      add(0, 1, 0, 1, 1, 7, 16'h0000, 16'hAB34, 3, 1);
      add(0, 0, 1, 1, 0, 7, 16'hABCD, 16'hAB34, 3, 2);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hAB34, 4, 2);
      add(0, 1, 0, 1, 1, 7, 16'h0000, 16'hABCD, 4, 2);
      add(0, 0, 1, 0, 0, 8, 16'h1111, 16'hABCD, 4, 3);  // window rule
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hABCD, 5, 3);
      add(0, 0, 1, 0, 0, 9, 16'h2222, 16'hABCD, 5, 3);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hABCD, 6, 3);
      add(0, 0, 1, 0, 0, 8, 16'h3333, 16'hABCD, 6, 3);
      add(0, 0, 1, 0, 0, 8, 16'h4444, 16'hABCD, 7, 3);
      add(0, 0, 1, 0, 0, 9, 16'h5555, 16'hABCD, 7, 3);
      add(0, 0, 1, 0, 0, 9, 16'h6666, 16'hABCD, 7, 3);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hABCD, 7, 3);
      add(0, 1, 0, 1, 1, 9, 16'h0000, 16'h2222, 7, 3);
      add(0, 1, 0, 1, 1, 8, 16'h0000, 16'h3333, 7, 4);
      add(0, 0, 1, 0, 0, 9, 16'h7777, 16'h3333, 7, 4);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h3333, 8, 4);
      add(0, 0, 1, 0, 0, 9, 16'h8888, 16'h3333, 8, 4);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h3333, 9, 4);
      add(0, 1, 0, 1, 1, 9, 16'h0000, 16'h8888, 9, 4);
      add(0, 0, 1, 0, 0, 2, 16'hBEEF, 16'h8888, 9, 5);  // two-halfword read
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h8888, 10, 5);
      add(0, 0, 1, 0, 0, 3, 16'hCAFE, 16'h8888, 10, 5);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h8888, 11, 5);
      add(0, 1, 0, 1, 1, 2, 16'h0000, 16'hBEEF, 11, 5);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hBEEF, 11, 6);
      add(0, 1, 0, 1, 1, 3, 16'h0000, 16'hCAFE, 11, 6);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hCAFE, 11, 7);
      add(0, 0, 0, 0, 0, 3, 16'h0000, 16'hCAFE, 11, 7);  // read-during-write
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'hCAFE, 12, 7);
      add(0, 1, 0, 1, 1, 3, 16'h0000, 16'h0000, 12, 7);
      add(1, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 12, 8);

      // Reset held with an active write window: nothing may commit.
      rst_n = 1'b0;
      bus.sram_ce_n = 0; bus.sram_we_n = 0; bus.sram_oe_n = 1; bus.sram_ub_n = 0;
      bus.sram_lb_n = 0; bus.sram_addr = 20'd5; bus.sram_wr_data = 16'hFFFF;
      bus_s.sram_ce_n = 1; bus_s.sram_we_n = 1; bus_s.sram_oe_n = 1; bus_s.sram_ub_n = 1;
      bus_s.sram_lb_n = 1; bus_s.sram_addr = '0; bus_s.sram_wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("reset wr_count", wc, 16'd0);
      chk("reset rd_count", rc, 16'd0);
      chk("reset rd_data", bus.sram_rd_data, 16'd0);
      chk("reset oob_err", {15'd0, oob}, 16'd0);
      chk("reset small oob_err", {15'd0, oob_s}, 16'd0);
      bus.sram_ce_n = 1; bus.sram_we_n = 1;
      rst_n = 1'b1;
      m_reset();

      foreach (tbl[i]) begin
         drive(0, tbl[i].ce, tbl[i].we, tbl[i].oe, tbl[i].ub, tbl[i].lb, tbl[i].a, tbl[i].d);
         chk($sformatf("vec%0d rd_data", i), bus.sram_rd_data, tbl[i].e_rd);
         chk($sformatf("vec%0d wr_count", i), wc, tbl[i].e_wc);
         chk($sformatf("vec%0d rd_count", i), rc, tbl[i].e_rc);
         m_tick();
      end

      // Known contents for the random phase.
      for (int a = 0; a < 16; a++) begin
         drive(0, 0, 0, 1, 0, 0, 20'(a), 16'($urandom));
         m_tick();
         drive(0, 1, 1, 1, 1, 1, 0, 0);
         m_tick();
      end

      for (int k = 0; k < 300; k++) begin
         logic [19:0] ra;
         ra = ($urandom_range(0, 7) == 0) ? 20'(4096 + $urandom_range(0, 1000))
                                          : 20'($urandom_range(0, 15));
         drive(0, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ra, 16'($urandom));
         chk($sformatf("rnd%0d rd_data", k), bus.sram_rd_data, m_rd());
         chk($sformatf("rnd%0d wr_count", k), wc, m_wc);
         chk($sformatf("rnd%0d rd_count", k), rc, m_rc);
         chk($sformatf("rnd%0d oob_err", k), {15'd0, oob}, {15'd0, m_oob});
         m_tick();
      end

      // Small array (16 words): out-of-range handling and counter wrap.
      drive(1, 0, 0, 1, 0, 0, 20'd3, 16'h5A5A);
      chk("small oob_err before oob", {15'd0, oob_s}, 16'd0);
      drive(1, 1, 1, 1, 1, 1, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 20'd19, 16'h0000);
      drive(1, 1, 1, 1, 1, 1, 0, 0);
      chk("oob write sets oob_err", {15'd0, oob_s}, 16'd1);
      chk("oob write counted", wc_s, 16'd2);
      drive(1, 0, 1, 0, 1, 1, 20'd3, 0);
      chk("oob write dropped", bus_s.sram_rd_data, 16'h5A5A);
      drive(1, 0, 1, 0, 1, 1, 20'd16, 0);
      chk("oob read data", bus_s.sram_rd_data, 16'hDEAD);
      drive(1, 1, 1, 1, 1, 1, 0, 0);
      chk("oob read hold", bus_s.sram_rd_data, 16'hDEAD);
      chk("small rd_count", rc_s, 16'd1);
      chk("oob_err sticky", {15'd0, oob_s}, 16'd1);
      force dut_s.wr_cnt_q = 16'hFFFF;
      #1;
      release dut_s.wr_cnt_q;
      drive(1, 0, 0, 1, 0, 0, 20'd4, 16'h1111);
      drive(1, 1, 1, 1, 1, 1, 0, 0);
      chk("wr_count wrap", wc_s, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
